// File: rtl/vga_scan_mixer_pkg.sv
// rtl/vga_scan_mixer_pkg.sv - shared VGA 640x480@60 timing constants and widths for the scan mixer
package vga_scan_mixer_pkg;

    localparam int H_DISP_LEN      = 10;
    localparam int V_DISP_LEN      = 9;
    localparam int COLOR_RGB_DEPTH = 12;
    localparam int CNT_W           = 10;

    localparam int H_ACTIVE = 640;
    localparam int H_FRONT  = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BACK   = 48;
    localparam int H_TOTAL  = 800;

    localparam int V_ACTIVE = 480;
    localparam int V_FRONT  = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BACK   = 33;
    localparam int V_TOTAL  = 525;

    typedef logic [COLOR_RGB_DEPTH-1:0] rgb_t;

endpackage

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - raster counters, raw syncs, active flag, request addresses and frame tick
module vga_timing_gen
    import vga_scan_mixer_pkg::*;
#(
    parameter int H_ACT_LEN  = H_ACTIVE,
    parameter int H_FP_LEN   = H_FRONT,
    parameter int H_SYNC_LEN = H_SYNC,
    parameter int H_BP_LEN   = H_BACK,
    parameter int V_ACT_LEN  = V_ACTIVE,
    parameter int V_FP_LEN   = V_FRONT,
    parameter int V_SYNC_LEN = V_SYNC,
    parameter int V_BP_LEN   = V_BACK
) (
    input  logic                  clk_vga,
    input  logic                  rst,
    output logic [H_DISP_LEN-1:0] req_x_addr_o,
    output logic [V_DISP_LEN-1:0] req_y_addr_o,
    output logic                  v_sync_o,
    output logic                  hsync_raw_o,
    output logic                  vsync_raw_o,
    output logic                  active_o
);

    localparam logic [CNT_W-1:0] H_ACT_END  = CNT_W'(H_ACT_LEN);
    localparam logic [CNT_W-1:0] H_SYNC_BEG = CNT_W'(H_ACT_LEN + H_FP_LEN);
    localparam logic [CNT_W-1:0] H_SYNC_END = CNT_W'(H_ACT_LEN + H_FP_LEN + H_SYNC_LEN);
    localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_ACT_LEN + H_FP_LEN + H_SYNC_LEN + H_BP_LEN - 1);
    localparam logic [CNT_W-1:0] V_ACT_END  = CNT_W'(V_ACT_LEN);
    localparam logic [CNT_W-1:0] V_SYNC_BEG = CNT_W'(V_ACT_LEN + V_FP_LEN);
    localparam logic [CNT_W-1:0] V_SYNC_END = CNT_W'(V_ACT_LEN + V_FP_LEN + V_SYNC_LEN);
    localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_ACT_LEN + V_FP_LEN + V_SYNC_LEN + V_BP_LEN - 1);

    logic [CNT_W-1:0] h_cnt_q, h_cnt_d;
    logic [CNT_W-1:0] v_cnt_q, v_cnt_d;

    // Next raster position: h wraps at end of line, v advances on each h wrap
    always_comb begin
        h_cnt_d = h_cnt_q + 1'b1;
        v_cnt_d = v_cnt_q;
        if (h_cnt_q == H_LAST) begin
            h_cnt_d = '0;
            v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;
        end
    end

    // Raster position registers; reset restarts the frame at (0,0)
    always_ff @(posedge clk_vga or negedge rst) begin
        if (!rst) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
        end
    end

    assign active_o     = (h_cnt_q < H_ACT_END) && (v_cnt_q < V_ACT_END);
    assign hsync_raw_o  = ~((h_cnt_q >= H_SYNC_BEG) && (h_cnt_q < H_SYNC_END));
    assign vsync_raw_o  = ~((v_cnt_q >= V_SYNC_BEG) && (v_cnt_q < V_SYNC_END));
    assign req_x_addr_o = active_o ? h_cnt_q[H_DISP_LEN-1:0] : '0;
    assign req_y_addr_o = active_o ? v_cnt_q[V_DISP_LEN-1:0] : '0;
    // Frame tick marks the first cycle of vertical blanking
    assign v_sync_o     = (h_cnt_q == '0) && (v_cnt_q == V_ACT_END);

endmodule

// File: rtl/vga_scan_mixer.sv
// rtl/vga_scan_mixer.sv - VGA timing initiator, layer compositor and collision flags (PLANEWAR_CRASH_DETECT_EN adds collision logic)
module vga_scan_mixer
    import vga_scan_mixer_pkg::*;
#(
    parameter int LAYER_LAT  = 1,
    parameter int H_ACT_LEN  = H_ACTIVE,
    parameter int H_FP_LEN   = H_FRONT,
    parameter int H_SYNC_LEN = H_SYNC,
    parameter int H_BP_LEN   = H_BACK,
    parameter int V_ACT_LEN  = V_ACTIVE,
    parameter int V_FP_LEN   = V_FRONT,
    parameter int V_SYNC_LEN = V_SYNC,
    parameter int V_BP_LEN   = V_BACK
) (
    input  logic                       clk_vga,
    input  logic                       rst,
    output logic [H_DISP_LEN-1:0]      req_x_addr_o,
    output logic [V_DISP_LEN-1:0]      req_y_addr_o,
    output logic                       v_sync_o,
    input  logic [COLOR_RGB_DEPTH-1:0] bg_rgb_i,
    input  logic                       bonus_alpha_i,
    input  logic                       me_alpha_i,
    input  logic                       enemy_alpha_i,
    input  logic                       bullet_alpha_i,
    input  logic [COLOR_RGB_DEPTH-1:0] bonus_rgb_i,
    input  logic [COLOR_RGB_DEPTH-1:0] me_rgb_i,
    input  logic [COLOR_RGB_DEPTH-1:0] enemy_rgb_i,
    input  logic [COLOR_RGB_DEPTH-1:0] bullet_rgb_i,
    output logic                       crash_me_bonus_o,
    output logic                       crash_me_enemy_o,
    output logic                       crash_bullet_enemy_o,
    output logic                       hsync_o,
    output logic                       vsync_o,
    output logic [COLOR_RGB_DEPTH-1:0] rgb_o
);

    logic active_s0;
    logic hsync_s0;
    logic vsync_s0;

    vga_timing_gen #(
        .H_ACT_LEN  (H_ACT_LEN),
        .H_FP_LEN   (H_FP_LEN),
        .H_SYNC_LEN (H_SYNC_LEN),
        .H_BP_LEN   (H_BP_LEN),
        .V_ACT_LEN  (V_ACT_LEN),
        .V_FP_LEN   (V_FP_LEN),
        .V_SYNC_LEN (V_SYNC_LEN),
        .V_BP_LEN   (V_BP_LEN)
    ) u_timing (
        .clk_vga      (clk_vga),
        .rst          (rst),
        .req_x_addr_o (req_x_addr_o),
        .req_y_addr_o (req_y_addr_o),
        .v_sync_o     (v_sync_o),
        .hsync_raw_o  (hsync_s0),
        .vsync_raw_o  (vsync_s0),
        .active_o     (active_s0)
    );

    // Active flag travels LAYER_LAT stages to line up with layer data; syncs travel one more to line up with rgb_o
    logic [LAYER_LAT-1:0] act_pipe_q;
    logic [LAYER_LAT:0]   hs_pipe_q;
    logic [LAYER_LAT:0]   vs_pipe_q;
    logic                 act_s1;
    rgb_t                 rgb_d, rgb_q;

    assign act_s1 = act_pipe_q[LAYER_LAT-1];

    // Alignment shift registers for the active flag and the syncs
    always_ff @(posedge clk_vga or negedge rst) begin
        if (!rst) begin
            act_pipe_q <= '0;
            hs_pipe_q  <= '1;
            vs_pipe_q  <= '1;
        end else begin
            act_pipe_q <= (act_pipe_q << 1) | LAYER_LAT'(active_s0);
            hs_pipe_q  <= (hs_pipe_q << 1) | (LAYER_LAT+1)'(hsync_s0);
            vs_pipe_q  <= (vs_pipe_q << 1) | (LAYER_LAT+1)'(vsync_s0);
        end
    end

    // Fixed-priority composite of the layer responses; blanking forces black
    always_comb begin
        rgb_d = '0;
        if (act_s1) begin
            if (me_alpha_i)          rgb_d = me_rgb_i;
            else if (bullet_alpha_i) rgb_d = bullet_rgb_i;
            else if (enemy_alpha_i)  rgb_d = enemy_rgb_i;
            else if (bonus_alpha_i)  rgb_d = bonus_rgb_i;
            else                     rgb_d = bg_rgb_i;
        end
    end

    // Output colour register
    always_ff @(posedge clk_vga or negedge rst) begin
        if (!rst) rgb_q <= '0;
        else      rgb_q <= rgb_d;
    end

    assign rgb_o   = rgb_q;
    assign hsync_o = hs_pipe_q[LAYER_LAT];
    assign vsync_o = vs_pipe_q[LAYER_LAT];

`ifdef PLANEWAR_CRASH_DETECT_EN
    // Bit order: {bullet&enemy, me&enemy, me&bonus}
    logic [2:0] pend_q, pend_d;
    logic [2:0] crash_q, crash_d;

    // Accumulate overlaps during the frame; the frame tick publishes and clears them
    always_comb begin
        pend_d  = pend_q;
        crash_d = crash_q;
        if (v_sync_o) begin
            crash_d = pend_q;
            pend_d  = '0;
        end else if (act_s1) begin
            pend_d = pend_q | {bullet_alpha_i & enemy_alpha_i,
                               me_alpha_i & enemy_alpha_i,
                               me_alpha_i & bonus_alpha_i};
        end
    end

    // Pending and published collision registers
    always_ff @(posedge clk_vga or negedge rst) begin
        if (!rst) begin
            pend_q  <= '0;
            crash_q <= '0;
        end else begin
            pend_q  <= pend_d;
            crash_q <= crash_d;
        end
    end

    assign crash_me_bonus_o     = crash_q[0];
    assign crash_me_enemy_o     = crash_q[1];
    assign crash_bullet_enemy_o = crash_q[2];
`else
    assign crash_me_bonus_o     = 1'b0;
    assign crash_me_enemy_o     = 1'b0;
    assign crash_bullet_enemy_o = 1'b0;
`endif

endmodule

// File: tb/tb_vga_scan_mixer.sv
// tb/tb_vga_scan_mixer.sv - scoreboard bench for vga_scan_mixer on a shrunken raster plus a full-size line check
module tb_vga_scan_mixer;

    localparam int HA = 40, HF = 4, HS = 8, HB = 4, HT = HA + HF + HS + HB;
    localparam int VA = 30, VF = 2, VS = 2, VB = 3, VT = VA + VF + VS + VB;
    localparam int FR = HT * VT;
    localparam int N_CYC = 3 * FR + 10 * HT + 20;

    typedef struct {
        logic [9:0]  rx;
        logic [8:0]  ry;
        logic        tick;
        logic        hs;
        logic        vs;
        logic [11:0] rgb;
        logic [2:0]  crash;
    } exp_t;

    logic clk_vga = 1'b0;
    logic rst     = 1'b0;

    logic [11:0] bg_rgb, bonus_rgb, me_rgb, enemy_rgb, bullet_rgb;
    logic        bonus_a, me_a, enemy_a, bullet_a;

    logic [9:0]  s_rx;
    logic [8:0]  s_ry;
    logic        s_tick, s_cmb, s_cme, s_cbe, s_hs, s_vs;
    logic [11:0] s_rgb;

    logic [9:0]  f_rx;
    logic [8:0]  f_ry;
    logic        f_tick, f_cmb, f_cme, f_cbe, f_hs, f_vs;
    logic [11:0] f_rgb;
    logic        zero_a = 1'b0;
    logic [11:0] zero_c = 12'h000;
    logic [11:0] full_bg = 12'h123;

    int   checks = 0;
    int   errors = 0;
    bit   mon_done = 0;
    bit   full_done = 0;
    exp_t sb_q[$];
    logic [2:0] coll [0:7];

    always #20 clk_vga = ~clk_vga;

    vga_scan_mixer #(
        .LAYER_LAT(1),
        .H_ACT_LEN(HA), .H_FP_LEN(HF), .H_SYNC_LEN(HS), .H_BP_LEN(HB),
        .V_ACT_LEN(VA), .V_FP_LEN(VF), .V_SYNC_LEN(VS), .V_BP_LEN(VB)
    ) dut (
        .clk_vga(clk_vga), .rst(rst),
        .req_x_addr_o(s_rx), .req_y_addr_o(s_ry), .v_sync_o(s_tick),
        .bg_rgb_i(bg_rgb),
        .bonus_alpha_i(bonus_a), .me_alpha_i(me_a), .enemy_alpha_i(enemy_a), .bullet_alpha_i(bullet_a),
        .bonus_rgb_i(bonus_rgb), .me_rgb_i(me_rgb), .enemy_rgb_i(enemy_rgb), .bullet_rgb_i(bullet_rgb),
        .crash_me_bonus_o(s_cmb), .crash_me_enemy_o(s_cme), .crash_bullet_enemy_o(s_cbe),
        .hsync_o(s_hs), .vsync_o(s_vs), .rgb_o(s_rgb)
    );

    vga_scan_mixer dut_full (
        .clk_vga(clk_vga), .rst(rst),
        .req_x_addr_o(f_rx), .req_y_addr_o(f_ry), .v_sync_o(f_tick),
        .bg_rgb_i(full_bg),
        .bonus_alpha_i(zero_a), .me_alpha_i(zero_a), .enemy_alpha_i(zero_a), .bullet_alpha_i(zero_a),
        .bonus_rgb_i(zero_c), .me_rgb_i(zero_c), .enemy_rgb_i(zero_c), .bullet_rgb_i(zero_c),
        .crash_me_bonus_o(f_cmb), .crash_me_enemy_o(f_cme), .crash_bullet_enemy_o(f_cbe),
        .hsync_o(f_hs), .vsync_o(f_vs), .rgb_o(f_rgb)
    );

    task automatic chk(input string name, input int m, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s cycle %0d got %0h want %0h", name, m, got, want);
        end
    endtask

    // Everything except the colour, derived from the cycle index since reset release
    function automatic exp_t model_item(input int m);
        exp_t e;
        int h, v, hp, vp, n;
        h = m % HT;
        v = (m / HT) % VT;
        e.rx   = ((h < HA) && (v < VA)) ? 10'(h) : 10'd0;
        e.ry   = ((h < HA) && (v < VA)) ? 9'(v) : 9'd0;
        e.tick = (h == 0) && (v == VA);
        e.hs   = 1'b1;
        e.vs   = 1'b1;
        if (m >= 2) begin
            hp = (m - 2) % HT;
            vp = ((m - 2) / HT) % VT;
            e.hs = !((hp >= HA + HF) && (hp < HA + HF + HS));
            e.vs = !((vp >= VA + VF) && (vp < VA + VF + VS));
        end
        e.rgb   = 12'h000;
        e.crash = 3'b000;
        n = m - 1;
        if (n >= VA * HT) begin
`ifdef PLANEWAR_CRASH_DETECT_EN
            e.crash = coll[(n - VA * HT) / FR];
`else
            e.crash = 3'b000;
`endif
        end
        return e;
    endfunction

    // Layer behaviour for raster position p: drives the inputs and returns the colour that must appear
    task automatic drive_pixel(input int p, output logic [11:0] want);
        int h, v, f;
        logic act;
        logic [31:0] r0, r1, r2;
        logic a_bon, a_me, a_en, a_bul;
        h = p % HT;
        v = (p / HT) % VT;
        f = p / FR;
        act = (h < HA) && (v < VA);
        r0 = $urandom();
        r1 = $urandom();
        r2 = $urandom();
        bg_rgb     = r0[11:0];
        me_rgb     = r1[11:0];
        bullet_rgb = r1[23:12];
        enemy_rgb  = r2[11:0];
        bonus_rgb  = r2[23:12];
        a_bon = r0[12]; a_me = r0[13]; a_en = r0[14]; a_bul = r0[15];
        if (f != 2) begin
            if (a_me && a_bon) a_bon = 1'b0;
            if (a_me && a_en)  a_en  = 1'b0;
            if (a_bul && a_en) a_en  = 1'b0;
        end
        if (f == 0 && h == 20 && v == 15) begin
            a_me = 1'b1; a_bon = 1'b1; a_en = 1'b0; a_bul = 1'b0;
        end
        if (f == 3 && v == 5 && h >= 10 && h <= 12) begin
            a_en = 1'b0; a_bul = 1'b0;
            a_me  = (h == 10);
            a_bon = (h != 12);
            me_rgb = 12'hF00;
            bonus_rgb = 12'h0F0;
        end
        if (!act) begin
            a_bon = 1'b1; a_me = 1'b1; a_en = 1'b1; a_bul = 1'b1;
        end
        bonus_a = a_bon; me_a = a_me; enemy_a = a_en; bullet_a = a_bul;
        want = 12'h000;
        if (act) begin
            if (a_me)       want = me_rgb;
            else if (a_bul) want = bullet_rgb;
            else if (a_en)  want = enemy_rgb;
            else if (a_bon) want = bonus_rgb;
            else            want = bg_rgb;
            coll[f] = coll[f] | {a_bul & a_en, a_me & a_en, a_me & a_bon};
        end
    endtask

    // Stimulus: reset checks, per-cycle layer responses with expectations queued, then a mid-frame reset
    initial begin
        exp_t e;
        logic [11:0] want;
        for (int i = 0; i < 8; i++) coll[i] = 3'b000;
        bg_rgb = 12'hABC; me_rgb = 12'h111; bullet_rgb = 12'h222; enemy_rgb = 12'h333; bonus_rgb = 12'h444;
        bonus_a = 1'b1; me_a = 1'b1; enemy_a = 1'b1; bullet_a = 1'b1;
        repeat (4) @(posedge clk_vga);
        @(negedge clk_vga);
        chk("rst_rgb", -1, 32'(s_rgb), 32'h0);
        chk("rst_hsync", -1, 32'(s_hs), 32'h1);
        chk("rst_vsync", -1, 32'(s_vs), 32'h1);
        chk("rst_crash", -1, 32'({s_cbe, s_cme, s_cmb}), 32'h0);
        chk("rst_req", -1, 32'({s_rx, s_ry}), 32'h0);
        chk("rst_tick", -1, 32'(s_tick), 32'h0);
        sb_q.push_back(model_item(0));
        sb_q.push_back(model_item(1));
        rst = 1'b1;
        for (int n = 1; n <= N_CYC; n++) begin
            @(posedge clk_vga);
            #1;
            drive_pixel(n - 1, want);
            e = model_item(n + 1);
            e.rgb = want;
            sb_q.push_back(e);
        end
        wait (mon_done && full_done);
        @(posedge clk_vga);
        #3;
        rst = 1'b0;
        #1;
        chk("mid_rst_rgb", -2, 32'(s_rgb), 32'h0);
        chk("mid_rst_hsync", -2, 32'(s_hs), 32'h1);
        chk("mid_rst_crash", -2, 32'({s_cbe, s_cme, s_cmb}), 32'h0);
        chk("mid_rst_req", -2, 32'({s_rx, s_ry}), 32'h0);
        @(negedge clk_vga);
        rst = 1'b1;
        @(negedge clk_vga);
        chk("restart_req_x", -3, 32'(s_rx), 32'h1);
        chk("restart_req_y", -3, 32'(s_ry), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Monitor: one scoreboard entry per output cycle of the shrunken-raster instance
    initial begin
        exp_t e;
        @(posedge rst);
        #1;
        for (int m = 0; m <= N_CYC; m++) begin
            if (m > 0) @(negedge clk_vga);
            if (sb_q.size() == 0) begin
                chk("sb_empty", m, 32'h1, 32'h0);
            end else begin
                e = sb_q.pop_front();
                chk("req_x", m, 32'(s_rx), 32'(e.rx));
                chk("req_y", m, 32'(s_ry), 32'(e.ry));
                chk("v_sync_tick", m, 32'(s_tick), 32'(e.tick));
                chk("hsync", m, 32'(s_hs), 32'(e.hs));
                chk("vsync", m, 32'(s_vs), 32'(e.vs));
                chk("rgb", m, 32'(s_rgb), 32'(e.rgb));
                chk("crash", m, 32'({s_cbe, s_cme, s_cmb}), 32'(e.crash));
            end
        end
        mon_done = 1;
    end

    // Full 640x480 instance: first lines of request addresses, colour and hsync shape
    initial begin
        int first_fall, second_fall, lows;
        logic prev_hs;
        first_fall = -1;
        second_fall = -1;
        lows = 0;
        prev_hs = 1'b1;
        @(posedge rst);
        #1;
        for (int m = 0; m < 1700; m++) begin
            if (m > 0) @(negedge clk_vga);
            chk("full_req_x", m, 32'(f_rx), ((m % 800) < 640) ? 32'(m % 800) : 32'h0);
            chk("full_rgb", m, 32'(f_rgb), (m >= 2 && ((m - 2) % 800) < 640) ? 32'h123 : 32'h0);
            if (prev_hs && !f_hs) begin
                if (first_fall < 0) first_fall = m;
                else if (second_fall < 0) second_fall = m;
            end
            if (m >= 658 && m < 1458 && !f_hs) lows++;
            prev_hs = f_hs;
        end
        chk("full_hsync_first_fall", 0, 32'(first_fall), 32'd658);
        chk("full_hsync_period", 0, 32'(second_fall - first_fall), 32'd800);
        chk("full_hsync_low_len", 0, 32'(lows), 32'd96);
        chk("full_vsync_line0", 0, 32'(f_vs), 32'h1);
        full_done = 1;
    end

    initial begin
        #(40 * 20000);
        $display("FAIL watchdog expired checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/vga_scan_mixer.md
# vga_scan_mixer

Frame-timing initiator and layer compositor for the PlaneWar display path. It generates 640x480@60 VGA timing on `clk_vga` and drives the pixel request address and frame tick to every sprite layer (bonus, me, enemy, bullet, background). It takes back each layer's alpha/rgb response, composites them by fixed priority and drives the VGA pins. It also produces the per-frame collision flags that the layers consume as `crash_*_i`.

## Interface
Parameters:
- `LAYER_LAT`, 1: cycles from request address to layer alpha/rgb response; only 1 is supported.

Ports (all synchronous to `clk_vga`):
- `clk_vga`  in  1  pixel clock, 25 MHz.
- `rst`  in  1  asynchronous, active-low reset.
- `req_x_addr_o`  out  `H_DISP_LEN`  column being requested, 0..639.
- `req_y_addr_o`  out  `V_DISP_LEN`  row being requested, 0..479.
- `v_sync_o`  out  1  one-cycle frame tick to the layers.
- `bg_rgb_i`  in  `COLOR_RGB_DEPTH`  background colour; always opaque.
- `bonus_alpha_i`, `me_alpha_i`, `enemy_alpha_i`, `bullet_alpha_i`  in  1 each  layer opacity.
- `bonus_rgb_i`, `me_rgb_i`, `enemy_rgb_i`, `bullet_rgb_i`  in  `COLOR_RGB_DEPTH` each  layer colour.
- `crash_me_bonus_o`, `crash_me_enemy_o`, `crash_bullet_enemy_o`  out  1 each  collision flags.
- `hsync_o`, `vsync_o`  out  1 each  VGA syncs, active-low.
- `rgb_o`  out  `COLOR_RGB_DEPTH`  VGA colour.

## Operation
- Two 10-bit counters, `h_cnt` (0..799) and `v_cnt` (0..524).
  - `h_cnt` wraps 799->0.
  - `v_cnt` increments when `h_cnt` wraps, and wraps 524->0.
- Horizontal timing: active 0..639, front porch 640..655, sync 656..751, back porch 752..799.
- Vertical timing: active 0..479, front porch 480..489, sync 490..491, back porch 492..524.
- Request addresses:
  - `req_x_addr_o` and `req_y_addr_o` are the counters truncated to their port widths.
  - Outside the active area they are driven to 0.
- Layers register their response, so data for the stage-0 address arrives at stage 1.
- Priority mux, applied only when the stage-1 pixel is active: me > bullet > enemy > bonus > background. The first layer with alpha=1 supplies the colour.
- Inactive pixels output `rgb_o` = 0; alpha inputs are ignored there.
- Collision detection, on active stage-1 pixels only:
  - Three pending bits: `me&bonus`, `me&enemy`, `bullet&enemy`. Each is set when both alphas are 1 on the same pixel.
  - On the `v_sync_o` cycle, the pending bits are copied into the `crash_*_o` registers and then cleared.
  - Each flag therefore stays constant for the whole following frame. Layers AND it with their own alpha.
- `v_sync_o` pulses for exactly one cycle when `h_cnt`=0 and `v_cnt`=480, i.e. start of vertical blanking. This is once per 420000 cycles.

## Timing
- Reset values: all counters, pending bits, `crash_*_o`, `rgb_o`, `req_*_o` and `v_sync_o` are 0. `hsync_o` and `vsync_o` are 1.
- First `clk_vga` edge after reset release: counters at (0,0), so the request for (0,0) is presented.
- Request-to-output pixel latency is 2 cycles: address at stage 0, layer data at stage 1, registered mux at stage 2.
- `hsync_o` and `vsync_o` are generated at stage 0 and delayed 2 cycles to stay aligned with `rgb_o`.
- `hsync_o` is low for 96 cycles per 800. `vsync_o` is low for 2 lines per 525.
- Collision set and the `v_sync_o` transfer never coincide, because the transfer happens in blanking. The transfer cycle has priority over a set in any case.
- Reset asserted mid-frame: all state returns to reset values immediately, without waiting for a clock edge. The frame restarts from (0,0) and any pending collisions are discarded.

## Configuration
- `PLANEWAR_CRASH_DETECT_EN` defined: the pending and flag registers exist and behave as described above.
- Undefined: no collision logic is built, and the three `crash_*_o` outputs are tied to 0. Mixing and timing are unchanged.

## Structure
- Shared header, alongside `H_DISP_LEN`, `V_DISP_LEN` and `COLOR_RGB_DEPTH`:
  - the eight timing constants (active, front porch, sync, back porch for H and V);
  - the totals 800 and 525;
  - the counter width 10.
- Sub-module `vga_timing_gen` owns the counters, raw syncs, active flag, request addresses and `v_sync_o`.
- The top level holds the stage-1 alignment registers, the priority mux and the collision logic.

## Test plan
- Reset, then release: outputs hold reset values. `hsync_o` first falls 658 cycles after release (656 plus 2 pipeline cycles). `req_x_addr_o` counts 0..639, then stays at 0 for 160 cycles.
- Free-run 2 frames: `hsync_o` period 800 cycles and low 96; `vsync_o` period 420000 cycles and low 1600; `v_sync_o` high exactly one cycle per frame, at `v_cnt`=480.
- Priority: at request (100,50), drive `me_alpha_i`=1 with `me_rgb_i`=0xF00 and `bonus_alpha_i`=1 with `bonus_rgb_i`=0x0F0 -> `rgb_o`=0xF00 two cycles after the request. With only bonus opaque -> 0x0F0. With no layer opaque -> `bg_rgb_i`.
- Collision: `me_alpha_i` and `bonus_alpha_i` both 1 at pixel (320,240) in frame N only -> `crash_me_bonus_o` goes 1 the cycle after `v_sync_o` ending frame N, stays 1 through frame N+1, drops after the next `v_sync_o`. The other two flags stay 0.
- Blanking: all alphas held at 1 during blanking -> `rgb_o`=0 there and no crash flag set.
- `PLANEWAR_CRASH_DETECT_EN` undefined, collision stimulus repeated -> all `crash_*_o` remain 0; `rgb_o` identical to the enabled build.
